// File: rtl/xgriscv_dmem_resp.sv
// Data-memory responder for the xgriscv load/store port: one request at a time,
// fixed access latency, RV32 byte/half/word lanes and fault detection.
module xgriscv_dmem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY) - CW'(1);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_c, access_c;

  logic          lat_we, lat_unsigned;
  logic [31:0]   lat_addr, lat_wdata;
  logic [1:0]    lat_size;

  logic          cur_we, cur_unsigned;
  logic [31:0]   cur_addr, cur_wdata;
  logic [1:0]    cur_size;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_c;
  logic          err_c, wr_c;
  logic [3:0]    mask_c;
  logic [31:0]   wsh_c, word_c, rsh_c, ld_c, rd_c;

  // Next-state logic; the access happens on whichever edge enters RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (LATENCY == 0) begin
            state_d  = RESP;
            access_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          access_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the access edge is also the accept edge, so use live inputs
  always_comb begin
    if (state_q == IDLE) begin
      cur_we       = req_we;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
    end else begin
      cur_we       = lat_we;
      cur_addr     = lat_addr;
      cur_wdata    = lat_wdata;
      cur_size     = lat_size;
      cur_unsigned = lat_unsigned;
    end
  end

  // Fault detection, lane mask and load extraction
  always_comb begin
    idx_c = cur_addr[AW+1:2];
    err_c = (cur_size == 2'b11) ||
            (cur_size == SZ_H && cur_addr[0]) ||
            (cur_size == SZ_W && cur_addr[1:0] != 2'b00) ||
            (|cur_addr[31:AW+2]);
    case (cur_size)
      SZ_B:    mask_c = 4'b0001 << cur_addr[1:0];
      SZ_H:    mask_c = 4'b0011 << {cur_addr[1], 1'b0};
      SZ_W:    mask_c = 4'b1111;
      default: mask_c = 4'b0000;
    endcase
    wsh_c  = cur_wdata << {cur_addr[1:0], 3'b000};
    wr_c   = access_c && cur_we && !err_c;
    word_c = mem[idx_c];
    rsh_c  = word_c >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      SZ_B:    ld_c = cur_unsigned ? {24'h0, rsh_c[7:0]}  : {{24{rsh_c[7]}}, rsh_c[7:0]};
      SZ_H:    ld_c = cur_unsigned ? {16'h0, rsh_c[15:0]} : {{16{rsh_c[15]}}, rsh_c[15:0]};
      default: ld_c = rsh_c;
    endcase
    rd_c = (cur_we || err_c) ? 32'h0 : ld_c;
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_c[i]) mem[idx_c][i*8 +: 8] <= wsh_c[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      if (accept_c) begin
        lat_we       <= req_we;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
      end
      if (access_c) begin
        resp_valid <= 1'b1;
        resp_rdata <= rd_c;
        resp_err   <= err_c;
      end else if (state_q == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_dmem_resp.sv
// Directed bench for xgriscv_dmem_resp: one instance at LATENCY=2, one at LATENCY=0.
module tb_xgriscv_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_we0, req_unsigned0;
  logic [31:0] req_addr0, req_wdata0;
  logic [1:0]  req_size0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xgriscv_dmem_resp #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  xgriscv_dmem_resp #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_size(req_size0),
    .req_unsigned(req_unsigned0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  // Called at a negedge while IDLE; returns at the negedge after acceptance
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
    req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_resp;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u,
                      output logic [31:0] rd, output logic er, output int n);
    issue(we, a, d, sz, u);
    wait_resp(n);
    rd = resp_rdata;
    er = resp_err;
    finish_resp();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", resp_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int n;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL sw_latency got %0d want 3", n); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_resp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL lw_latency got %0d want 3", n); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_resp got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int n;
    logic [31:0] ta [4] = '{32'h11, 32'h11, 32'h10, 32'h12};
    logic [1:0]  ts [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        tu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] te [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80EF, 32'h0000DEAD};
    xfer(1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, rd, er, n);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sb_err got %b want 0", er); end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, ta[i], 32'h0, ts[i], tu[i], rd, er, n);
      n_cmp++;
      if (rd !== te[i] || er !== 1'b0)
        begin n_bad++; $display("FAIL subword_load%0d got rdata=%h err=%b want rdata=%h err=0", i, rd, er, te[i]); end
    end
  endtask

  task automatic test_faults;
    logic [31:0] rd; logic er; int n;
    logic        fw [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] fa [5] = '{32'h13, 32'h12, 32'h0, 32'h1000, 32'h11};
    logic [1:0]  fs [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 5; i++) begin
      xfer(fw[i], fa[i], 32'h11111111, fs[i], 1'b0, rd, er, n);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || n !== 3)
        begin n_bad++; $display("FAIL fault%0d got err=%b rdata=%h lat=%0d want err=1 rdata=0 lat=3", i, er, rd, n); end
    end
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 32'hDEAD80EF || er !== 1'b0) begin n_bad++; $display("FAIL fault_mem_intact got %h err=%b want dead80ef err=0", rd, er); end
  endtask

  task automatic test_backpressure;
    int n;
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    wait_resp(n);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 32'h13; req_size = 2'b11; req_we = 1'b1;
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD80EF || resp_err !== 1'b0 || req_ready !== 1'b0)
        begin n_bad++; $display("FAIL backpressure%0d got v=%b rdata=%h err=%b rdy=%b want v=1 rdata=dead80ef err=0 rdy=0",
                                i, resp_valid, resp_rdata, resp_err, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_hold got %b want 0", req_ready); end
    finish_resp();
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_complete got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; logic er; int n;
    xfer(1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er, n);
    issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin n_bad++; $display("FAIL midreset_outputs got rdy=%b v=%b rdata=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin n_bad++; $display("FAIL midreset_mem got %h err=%b want a5a5a5a5 err=0", rd, er); end
  endtask

  task automatic test_back_to_back;
    logic        bw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ba [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h6};
    logic [31:0] bd [5] = '{32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'h0, 32'h0};
    logic [1:0]  bs [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [31:0] be [5] = '{32'h0, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'hFFFFBBBB};
    int prev = 0;
    resp_ready0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_we0 = bw[i]; req_addr0 = ba[i]; req_wdata0 = bd[i]; req_size0 = bs[i];
      req_unsigned0 = 1'b0; req_valid0 = 1'b1;
      n_cmp++; if (req_ready0 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d got %b want 1", i, req_ready0); end
      if (i > 0) begin
        n_cmp++; if (cyc - prev !== 2) begin n_bad++; $display("FAIL b2b_spacing%0d got %0d want 2", i, cyc - prev); end
      end
      prev = cyc;
      @(negedge clk);
      n_cmp++;
      if (resp_valid0 !== 1'b1 || resp_rdata0 !== be[i] || resp_err0 !== 1'b0 || req_ready0 !== 1'b0)
        begin n_bad++; $display("FAIL b2b_resp%0d got v=%b rdata=%h err=%b rdy=%b want v=1 rdata=%h err=0 rdy=0",
                                i, resp_valid0, resp_rdata0, resp_err0, req_ready0, be[i]); end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b10; req_unsigned = 1'b0; resp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
    req_size0 = 2'b10; req_unsigned0 = 1'b0; resp_ready0 = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
